// File: rtl/regfile_pkg.sv
// Shared types and constants for the LEGv8 register-file write-back path.
package regfile_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] XZR_IDX = 5'd31;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_MEM,
        WB_FIFO,
        WB_ALU
    } wb_src_e;

    function automatic logic [NUM_REGS-1:0] reg_bit(input logic [ADDR_W-1:0] idx);
        reg_bit      = '0;
        reg_bit[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding ALU results that lost the write port.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  wb_entry_t                  push_entry,
    input  logic                       pop,
    output wb_entry_t                  head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = store[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) store[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: loads first, then queued ALU results, then
// ALU bypass; plus a pending-write scoreboard for decode RAW stalls.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            issue_valid,
    input  logic [ADDR_W-1:0]               issue_rd,
    input  logic                            alu_valid,
    output logic                            alu_ready,
    input  logic [ADDR_W-1:0]               alu_rd,
    input  logic [DATA_W-1:0]               alu_data,
    input  logic                            mem_valid,
    input  logic [ADDR_W-1:0]               mem_rd,
    input  logic [DATA_W-1:0]               mem_data,
    input  logic [ADDR_W-1:0]               ra1,
    input  logic [ADDR_W-1:0]               ra2,
    output logic                            busy1,
    output logic                            busy2,
    output logic [ADDR_W-1:0]               wa3,
    output logic [DATA_W-1:0]               wd3,
    output logic                            we3,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    import regfile_pkg::*;

    logic                alu_fire;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    wb_entry_t           fifo_head;
    wb_entry_t           alu_entry;
    wb_src_e             src_p0;
    wb_entry_t           sel_p0;
    logic                vld_p0;
    logic [NUM_REGS-1:0] sb;
    logic [NUM_REGS-1:0] sb_set;
    logic [NUM_REGS-1:0] sb_clr;

    // Ready deliberately ignores a same-cycle pop so full never needs push+pop.
    assign alu_ready = !reset && !fifo_full;
    assign alu_fire  = alu_valid && alu_ready;
    assign alu_entry = '{rd: alu_rd, data: alu_data};

    // Stage p0: pick the write-port source by fixed priority.
    always_comb begin
        src_p0 = WB_NONE;
        sel_p0 = alu_entry;
        if (mem_valid) begin
            src_p0 = WB_MEM;
            sel_p0 = '{rd: mem_rd, data: mem_data};
        end else if (!fifo_empty) begin
            src_p0 = WB_FIFO;
            sel_p0 = fifo_head;
        end else if (alu_fire) begin
            src_p0 = WB_ALU;
        end
    end

    assign vld_p0    = (src_p0 != WB_NONE);
    assign fifo_pop  = (src_p0 == WB_FIFO);
    assign fifo_push = alu_fire && (src_p0 != WB_ALU);

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_entry (alu_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Stage p1: registered write port; XZR results are consumed without a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            we3 <= 1'b0;
            wa3 <= '0;
            wd3 <= '0;
        end else begin
            we3 <= vld_p0 && (sel_p0.rd != XZR_IDX);
            if (vld_p0) begin
                wa3 <= sel_p0.rd;
                wd3 <= sel_p0.data;
            end
        end
    end

    // A clear lands as the register file commits; a same-edge issue re-arms the bit.
    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (issue_valid && (issue_rd != XZR_IDX)) sb_set = reg_bit(issue_rd);
        if (we3)                                  sb_clr = reg_bit(wa3);
    end

    always_ff @(posedge clk) begin
        if (reset) sb <= '0;
        else       sb <= (sb & ~sb_clr) | sb_set;
    end

    assign busy1 = (ra1 != XZR_IDX) && sb[ra1];
    assign busy2 = (ra2 != XZR_IDX) && sb[ra2];

endmodule
